// File: rtl/phase_step_ctrl.sv
// Turns phase-detector shift pulses and software step requests into PLL dynamic
// phase-shift handshakes, tracking phase position and lock state.
module phase_step_ctrl #(
    parameter int         PHASE_STEPS = 56,
    parameter int         PHASE_W     = 6,
    parameter logic [2:0] CNTSEL      = 3'd2,
    parameter int         SETTLE      = 16,
    parameter int         TIMEOUT     = 1023,
    parameter int         LOCK_CNT    = 4095
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               shift,
    input  logic               sw_up,
    input  logic               sw_down,
    input  logic               clr_err,
    input  logic               pll_phasedone,
    output logic               pll_phasestep,
    output logic               pll_updown,
    output logic [2:0]         pll_cntsel,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               locked,
    output logic               overrun,
    output logic               timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + SETTLE + 2);
    localparam int QW    = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   ST_LAST    = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_MAX  = PHASE_W'(PHASE_STEPS - 1);
    localparam logic [QW-1:0]      QUIET_MAX  = QW'(LOCK_CNT);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_WAIT_LO, S_WAIT_HI, S_SETTLE, S_ABORT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [QW-1:0]    quiet;
    logic             pend_vld, pend_dir;
    logic             load, done;
    logic             req_sh, req_any, req_multi, req_dir;
    logic             pend_free, accept, ovr_set;

    assign pll_cntsel = CNTSEL;
    assign busy       = (state != S_IDLE);
    assign locked     = (quiet == QUIET_MAX);

    // sw_down outranks sw_up outranks shift; only the winner may be captured
    assign req_sh    = shift & enable;
    assign req_any   = sw_down | sw_up | req_sh;
    assign req_multi = (sw_down & sw_up) | (sw_down & req_sh) | (sw_up & req_sh);
    assign req_dir   = ~sw_down;

    // the slot frees up in the same cycle IDLE consumes it
    assign pend_free = ~pend_vld | load;
    assign accept    = req_any & pend_free;
    assign ovr_set   = req_any & (~pend_free | req_multi);

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        done          = 1'b0;
        pll_phasestep = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_vld) begin
                    load      = 1'b1;
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                pll_phasestep = 1'b1;
                if (cnt == STEP_LAST) state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!pll_phasedone)      state_nxt = S_WAIT_HI;
                else if (cnt == TO_LAST) state_nxt = S_ABORT;
            end
            S_WAIT_HI: begin
                if (pll_phasedone) begin
                    done      = 1'b1;
                    state_nxt = S_SETTLE;
                end else if (cnt == TO_LAST) begin
                    state_nxt = S_ABORT;
                end
            end
            S_SETTLE: begin
                if (cnt == ST_LAST) state_nxt = S_IDLE;
            end
            S_ABORT:  state_nxt = S_SETTLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pend_vld   <= 1'b0;
            pend_dir   <= 1'b0;
            pll_updown <= 1'b0;
            phase      <= '0;
            quiet      <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state <= state_nxt;

            // per-state cycle counter, restarted on every state change
            if (state_nxt != state)  cnt <= '0;
            else if (state != S_IDLE) cnt <= cnt + 1'b1;

            if (accept) begin
                pend_vld <= 1'b1;
                pend_dir <= req_dir;
            end else if (load) begin
                pend_vld <= 1'b0;
            end

            if (load) pll_updown <= pend_dir;

            if (done) begin
                if (pll_updown) phase <= (phase == PHASE_MAX) ? '0 : phase + 1'b1;
                else            phase <= (phase == '0) ? PHASE_MAX : phase - 1'b1;
            end

            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;

            if (state == S_ABORT) timeout <= 1'b1;
            else if (clr_err)     timeout <= 1'b0;

            if (!enable || state != S_IDLE || pend_vld || req_any) quiet <= '0;
            else if (quiet != QUIET_MAX)                             quiet <= quiet + 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_step_ctrl.sv
// Directed bench for phase_step_ctrl with a simple PLL phasedone model.
module tb_phase_step_ctrl;

    logic       clk = 1'b0;
    logic       reset, enable, shift, sw_up, sw_down, clr_err, pll_phasedone;
    logic       pll_phasestep, pll_updown, busy, locked, overrun, timeout;
    logic [2:0] pll_cntsel;
    logic [5:0] phase;

    int  checks = 0;
    int  errors = 0;
    int  strobe_cnt = 0;
    bit  pll_respond = 1'b1;

    phase_step_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .shift(shift),
        .sw_up(sw_up), .sw_down(sw_down), .clr_err(clr_err),
        .pll_phasedone(pll_phasedone), .pll_phasestep(pll_phasestep),
        .pll_updown(pll_updown), .pll_cntsel(pll_cntsel), .phase(phase),
        .busy(busy), .locked(locked), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // PLL: phasedone drops 3 cycles after strobe start, returns 5 cycles later
    initial forever begin
        @(posedge pll_phasestep);
        if (pll_respond) begin
            repeat (3) @(posedge clk);
            #1 pll_phasedone = 1'b0;
            repeat (5) @(posedge clk);
            #1 pll_phasedone = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (pll_phasestep) strobe_cnt++;
    end

    typedef struct {
        logic up, dn, sh, en, clr;
        int   ph;
        logic ud, ovr;
        int   stb;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic pulse(input logic up, input logic dn, input logic sh, input logic en, input logic clr);
        @(negedge clk);
        sw_up = up; sw_down = dn; shift = sh; enable = en; clr_err = clr;
        @(negedge clk);
        sw_up = 1'b0; sw_down = 1'b0; shift = 1'b0; clr_err = 1'b0; enable = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int low = 0;
        int n = 0;
        while (low < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            low = busy ? 0 : low + 1;
        end
        if (n >= 5000) bound_fail(name);
    endtask

    initial begin
        int n;
        vecs[0] = '{up:0, dn:1, sh:0, en:1, clr:0, ph:0,  ud:0, ovr:0, stb:2};
        vecs[1] = '{up:0, dn:1, sh:0, en:1, clr:0, ph:55, ud:0, ovr:0, stb:2};
        vecs[2] = '{up:0, dn:0, sh:1, en:1, clr:0, ph:0,  ud:1, ovr:0, stb:2};
        vecs[3] = '{up:1, dn:0, sh:0, en:1, clr:0, ph:1,  ud:1, ovr:0, stb:2};
        vecs[4] = '{up:1, dn:1, sh:0, en:1, clr:0, ph:0,  ud:0, ovr:1, stb:2};
        vecs[5] = '{up:0, dn:0, sh:1, en:0, clr:0, ph:0,  ud:0, ovr:1, stb:0};
        vecs[6] = '{up:1, dn:0, sh:0, en:0, clr:1, ph:1,  ud:1, ovr:0, stb:2};
        vecs[7] = '{up:1, dn:0, sh:1, en:1, clr:0, ph:2,  ud:1, ovr:1, stb:2};

        reset = 1'b1; enable = 1'b0; shift = 1'b0; sw_up = 1'b0; sw_down = 1'b0;
        clr_err = 1'b0; pll_phasedone = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", pll_phasestep, 0);
        check("rst_updown", pll_updown, 0);
        check("rst_cntsel", pll_cntsel, 3'd2);
        check("rst_flags", {locked, overrun, timeout}, 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // single shift: strobe width, direction, completion and settle timing
        strobe_cnt = 0;
        pulse(0, 0, 1, 1, 0);
        check("t1_pending_busy", busy, 0);
        @(negedge clk);
        check("t1_strobe", pll_phasestep, 1);
        check("t1_updown", pll_updown, 1);
        check("t1_busy", busy, 1);
        n = 0;
        while (phase != 6'd1 && n < 100) begin @(negedge clk); n++; end
        check("t1_done_latency", n, 9);
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        check("t1_settle_len", n, 16);
        check("t1_strobe_cycles", strobe_cnt, 2);
        wait_idle("t1_idle");

        for (int i = 0; i < 8; i++) begin
            strobe_cnt = 0;
            pulse(vecs[i].up, vecs[i].dn, vecs[i].sh, vecs[i].en, vecs[i].clr);
            wait_idle($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_phase", i), phase, vecs[i].ph);
            check($sformatf("vec%0d_updown", i), pll_updown, vecs[i].ud);
            check($sformatf("vec%0d_overrun", i), overrun, vecs[i].ovr);
            check($sformatf("vec%0d_strobes", i), strobe_cnt, vecs[i].stb);
        end
        pulse(0, 0, 0, 1, 1);
        check("clr_overrun", overrun, 0);

        // three shifts while busy: one served, one pending, one dropped
        strobe_cnt = 0;
        pulse(0, 0, 1, 1, 0);
        pulse(0, 0, 1, 1, 0);
        pulse(0, 0, 1, 1, 0);
        check("burst_overrun", overrun, 1);
        wait_idle("burst_idle");
        check("burst_phase", phase, 4);
        check("burst_strobes", strobe_cnt, 4);
        pulse(0, 0, 0, 1, 1);
        check("burst_clr", overrun, 0);

        // PLL never answers: abort after TIMEOUT cycles in WAIT_LO
        pll_respond = 1'b0;
        pulse(0, 0, 1, 1, 0);
        repeat (1026) @(negedge clk);
        check("to_before", timeout, 0);
        @(negedge clk);
        check("to_set", timeout, 1);
        repeat (15) @(negedge clk);
        check("to_settle_busy", busy, 1);
        @(negedge clk);
        check("to_settle_end", busy, 0);
        check("to_phase", phase, 4);
        pll_respond = 1'b1;
        pulse(0, 0, 0, 1, 1);
        check("to_clr", timeout, 0);

        // lock after LOCK_CNT quiet cycles
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("lock_en0", locked, 0);
        enable = 1'b1;
        repeat (4094) @(negedge clk);
        check("lock_early", locked, 0);
        @(negedge clk);
        check("lock_set", locked, 1);
        shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        check("lock_drop_shift", locked, 0);
        wait_idle("lock_step_idle");
        check("lock_phase", phase, 5);
        n = 0;
        while (!locked && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) bound_fail("relock");
        enable = 1'b0;
        shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        check("lock_disable", locked, 0);
        repeat (5) @(negedge clk);
        check("dis_shift_busy", busy, 0);
        check("dis_shift_phase", phase, 5);
        enable = 1'b1;

        // asynchronous reset while waiting for phasedone to rise
        pulse(1, 0, 1, 1, 0);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_overrun", overrun, 1);
        check("pre_rst_phasedone", pll_phasedone, 0);
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_strobe", pll_phasestep, 0);
        check("arst_phase", phase, 0);
        check("arst_flags", {overrun, timeout, locked}, 0);
        check("arst_cntsel", pll_cntsel, 3'd2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        strobe_cnt = 0;
        pulse(0, 0, 1, 1, 0);
        wait_idle("post_rst_idle");
        check("post_rst_phase", phase, 1);
        check("post_rst_strobes", strobe_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
